// File: rtl/emaclite_fifo_wr_arbiter_if.sv
// Requester lanes and FIFO write-side signals shared by the emaclite write arbiter.
// master = producers plus FIFO model side, slave = arbiter side.
interface emaclite_fifo_wr_arbiter_if #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_DATA_WIDTH = 6
);
    localparam int ID_W = $clog2(C_NUM_REQ);

    logic [C_NUM_REQ-1:0]              Req_valid;
    logic [C_NUM_REQ-1:0]              Req_last;
    logic [C_NUM_REQ*C_DATA_WIDTH-1:0] Req_data;
    logic [C_NUM_REQ-1:0]              Req_ready;
    logic [C_NUM_REQ-1:0]              Grant;
    logic [ID_W-1:0]                   Grant_id;
    logic [C_DATA_WIDTH-1:0]           Fifo_din;
    logic                              Fifo_wr_en;
    logic                              Fifo_full;
    logic                              Fifo_wr_ack;
    logic                              Ack_err;

    modport master (
        output Req_valid, Req_last, Req_data, Fifo_full, Fifo_wr_ack,
        input  Req_ready, Grant, Grant_id, Fifo_din, Fifo_wr_en, Ack_err
    );

    modport slave (
        input  Req_valid, Req_last, Req_data, Fifo_full, Fifo_wr_ack,
        output Req_ready, Grant, Grant_id, Fifo_din, Fifo_wr_en, Ack_err
    );
endinterface

// File: rtl/emaclite_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the emaclite async FIFO write port.
// Optional write-acknowledge checking is enabled by defining EMACLITE_ARB_ACK_CHECK_EN.
module emaclite_fifo_wr_arbiter #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_DATA_WIDTH = 6,
    parameter int C_MAX_BURST  = 16
) (
    input  logic                      Wr_clk,
    input  logic                      Ainit,
    emaclite_fifo_wr_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(C_NUM_REQ);
    localparam int BCNT_W = $clog2(C_MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(C_MAX_BURST - 1);
    localparam logic [ID_W-1:0]   ID_MAX    = ID_W'(C_NUM_REQ - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_reg;
    logic [C_NUM_REQ-1:0]    grant_reg;
    logic [ID_W-1:0]         grant_id_reg;
    logic [ID_W-1:0]         rr_ptr_reg;
    logic [BCNT_W-1:0]       bcnt_reg;

    logic                    pick_any;
    logic [ID_W-1:0]         pick_id;
    logic [C_NUM_REQ-1:0]    pick_oh;
    logic                    wr_en;
    logic                    burst_end;
    logic [ID_W-1:0]         rr_ptr_next;
    logic [C_DATA_WIDTH-1:0] lane_masked [C_NUM_REQ];
    logic [C_DATA_WIDTH-1:0] din_mux;

    // Walk candidates from the highest offset down so the last hit is the
    // first valid requester at or after rr_ptr (with wrap-around).
    always_comb begin
        int idx;
        idx      = 0;
        pick_any = |bus.Req_valid;
        pick_id  = '0;
        for (int k = C_NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= C_NUM_REQ) idx = idx - C_NUM_REQ;
            if (bus.Req_valid[ID_W'(idx)]) pick_id = ID_W'(idx);
        end
    end

    assign pick_oh     = C_NUM_REQ'(1) << pick_id;
    assign rr_ptr_next = (grant_id_reg == ID_MAX) ? '0 : grant_id_reg + 1'b1;

    // Grant is one-hot and zero in IDLE, so masking each lane by its grant bit
    // both selects lane g and forces Fifo_din to 0 when idle.
    for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_lane
        assign lane_masked[gi]   = bus.Req_data[gi*C_DATA_WIDTH +: C_DATA_WIDTH]
                                   & {C_DATA_WIDTH{grant_reg[gi]}};
        assign bus.Req_ready[gi] = grant_reg[gi] & wr_en;
    end

    always_comb begin
        din_mux = '0;
        for (int k = 0; k < C_NUM_REQ; k++) din_mux = din_mux | lane_masked[k];
    end

    assign wr_en     = (state_reg == BURST) & (|(grant_reg & bus.Req_valid))
                       & ~bus.Fifo_full & ~Ainit;
    assign burst_end = wr_en & ((|(grant_reg & bus.Req_last)) | (bcnt_reg == BCNT_LAST));

    assign bus.Fifo_wr_en = wr_en;
    assign bus.Fifo_din   = din_mux;
    assign bus.Grant      = grant_reg;
    assign bus.Grant_id   = grant_id_reg;

    always_ff @(posedge Wr_clk) begin
        if (Ainit) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            rr_ptr_reg   <= '0;
            bcnt_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        grant_reg    <= pick_oh;
                        grant_id_reg <= pick_id;
                        bcnt_reg     <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    // Stalls (full or valid gap) leave grant and count untouched.
                    if (burst_end) begin
                        grant_reg    <= '0;
                        grant_id_reg <= '0;
                        rr_ptr_reg   <= rr_ptr_next;
                        bcnt_reg     <= '0;
                        state_reg    <= IDLE;
                    end else if (wr_en) begin
                        bcnt_reg <= bcnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef EMACLITE_ARB_ACK_CHECK_EN
    logic pend_reg;
    logic ack_err_reg;

    // The FIFO acknowledges one cycle after the write; a missing ack is sticky.
    always_ff @(posedge Wr_clk) begin
        if (Ainit) begin
            pend_reg    <= 1'b0;
            ack_err_reg <= 1'b0;
        end else begin
            pend_reg <= wr_en;
            if (pend_reg && !bus.Fifo_wr_ack) ack_err_reg <= 1'b1;
        end
    end

    assign bus.Ack_err = ack_err_reg;
`else
    logic unused_ack;
    assign unused_ack  = bus.Fifo_wr_ack;
    assign bus.Ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_emaclite_fifo_wr_arbiter.sv
// Randomized and directed bench for emaclite_fifo_wr_arbiter against a cycle-level
// reference model of the arbitration rules; reports one line per completed burst.
module tb_emaclite_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 6;
    localparam int MB = 16;
`ifdef EMACLITE_ARB_ACK_CHECK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic ainit;
    always #5 clk = ~clk;

    emaclite_fifo_wr_arbiter_if #(.C_NUM_REQ(N), .C_DATA_WIDTH(W)) bus ();

    emaclite_fifo_wr_arbiter #(.C_NUM_REQ(N), .C_DATA_WIDTH(W), .C_MAX_BURST(MB)) dut (
        .Wr_clk (clk),
        .Ainit  (ainit),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Producer lanes: circular word stores of {last, data}.
    logic [W:0] mem [N][64];
    int  head [N];
    int  tail [N];
    bit  gate [N];

    // Stimulus knobs and FIFO model.
    bit  ainit_drv;
    bit  full_drv;
    int  full_pct;
    int  gate_pct;
    int  drop_at;
    int  rand_drop_pct;
    int  wr_num;
    bit  ack_due;

    // Reference model state.
    int  m_owner;
    int  m_sent;
    int  m_ptr;
    bit  m_pend;
    bit  m_err;

    // Observation logs.
    int         glog [$];
    int         blog [$];
    logic [W-1:0] wlog [$];
    int         cur_len;
    int         cur_lane;
    logic [N-1:0] prev_grant;

    function automatic int qget(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic push_word(input int lane, input int data, input bit last);
        mem[lane][tail[lane] % 64] = {last, W'(data)};
        tail[lane]++;
    endtask

    task automatic push_burst(input int lane, input int len, input bit with_last);
        for (int j = 0; j < len; j++)
            push_word(lane, int'($urandom_range(0, (1 << W) - 1)), with_last && (j == len - 1));
    endtask

    task automatic step();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_din;
        int           exp_id;
        bit           exp_wr;
        bit           v;
        @(posedge clk);
        #1;
        ainit = ainit_drv;
        full_drv = (full_pct > 0) ? ($urandom_range(0, 99) < full_pct) : full_drv;
        for (int i = 0; i < N; i++) begin
            if (gate_pct > 0) gate[i] = ($urandom_range(0, 99) < gate_pct);
            v = gate[i] && (head[i] != tail[i]);
            bus.Req_valid[i] = v;
            bus.Req_last[i]  = v ? mem[i][head[i] % 64][W] : 1'($urandom_range(0, 1));
            bus.Req_data[i*W +: W] = v ? mem[i][head[i] % 64][W-1:0] : W'($urandom);
        end
        bus.Fifo_full   = full_drv;
        bus.Fifo_wr_ack = ack_due;

        @(negedge clk);
        exp_wr    = (m_owner >= 0) && bus.Req_valid[m_owner] && !bus.Fifo_full && !ainit;
        exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        exp_id    = (m_owner >= 0) ? m_owner : 0;
        exp_din   = (m_owner >= 0) ? bus.Req_data[m_owner*W +: W] : '0;
        exp_ready = exp_wr ? N'(1 << m_owner) : '0;
        check("grant",    32'(bus.Grant),      32'(exp_grant));
        check("grant_id", 32'(bus.Grant_id),   32'(exp_id));
        check("wr_en",    32'(bus.Fifo_wr_en), 32'(exp_wr));
        check("din",      32'(bus.Fifo_din),   32'(exp_din));
        check("ready",    32'(bus.Req_ready),  32'(exp_ready));
        check("ack_err",  32'(bus.Ack_err),    32'(m_err));

        if (prev_grant != '0 && bus.Grant == '0) begin
            blog.push_back(cur_len);
            $display("burst lane=%0d words=%0d t=%0t", cur_lane, cur_len, $time);
        end
        if (prev_grant == '0 && bus.Grant != '0) begin
            glog.push_back(int'(bus.Grant_id));
            cur_lane = int'(bus.Grant_id);
            cur_len  = 0;
        end
        if (bus.Fifo_wr_en) begin
            cur_len++;
            wlog.push_back(bus.Fifo_din);
        end
        prev_grant = bus.Grant;

        for (int i = 0; i < N; i++)
            if (bus.Req_ready[i]) head[i]++;

        if (bus.Fifo_wr_en) begin
            wr_num++;
            ack_due = (wr_num != drop_at) && ($urandom_range(0, 99) >= rand_drop_pct);
        end else begin
            ack_due = 1'b0;
        end

        if (ainit) begin
            m_owner = -1; m_sent = 0; m_ptr = 0; m_pend = 0; m_err = 0;
        end else begin
            if (ACK_EN && m_pend && !bus.Fifo_wr_ack) m_err = 1'b1;
            m_pend = exp_wr;
            if (m_owner < 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (bus.Req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_sent = 0;
            end else if (exp_wr) begin
                m_sent++;
                if (bus.Req_last[m_owner] || m_sent == MB) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) begin
            head[i] = 0; tail[i] = 0; gate[i] = 1'b1;
        end
        full_drv = 1'b0; full_pct = 0; gate_pct = 0;
        drop_at = -1; rand_drop_pct = 0;
        ainit_drv = 1'b1;
        step();
        step();
        ainit_drv = 1'b0;
        wr_num = 0;
        glog.delete(); blog.delete(); wlog.delete();
    endtask

    task automatic wait_words(input int n, input string tag);
        int guard = 0;
        while (wlog.size() < n && guard < 40) begin
            step();
            guard++;
        end
        check(tag, 32'(wlog.size() >= n), 32'd1);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ainit = 1'b1;
        bus.Req_valid = '0; bus.Req_last = '0; bus.Req_data = '0;
        bus.Fifo_full = 1'b0; bus.Fifo_wr_ack = 1'b0;
        ack_due = 1'b0; wr_num = 0; prev_grant = '0; cur_len = 0; cur_lane = 0;
        m_owner = -1; m_sent = 0; m_ptr = 0; m_pend = 0; m_err = 0;

        // Reset state
        reset_dut();
        check("rst_grant",   32'(bus.Grant),      32'd0);
        check("rst_wr_en",   32'(bus.Fifo_wr_en), 32'd0);
        check("rst_ack_err", 32'(bus.Ack_err),    32'd0);

        // Single requester, three words, then rr_ptr evidence
        reset_dut();
        push_word(1, 'h11, 0); push_word(1, 'h22, 0); push_word(1, 'h33, 1);
        repeat (6) step();
        check("single_grant", 32'(qget(glog, 0)), 32'd1);
        check("single_words", 32'(wlog.size()), 32'd3);
        check("single_w0", 32'(wlog.size() > 0 ? wlog[0] : '1), 32'h11);
        check("single_w1", 32'(wlog.size() > 1 ? wlog[1] : '1), 32'h22);
        check("single_w2", 32'(wlog.size() > 2 ? wlog[2] : '1), 32'h33);
        push_word(0, 'h05, 1); push_word(2, 'h06, 1);
        repeat (6) step();
        check("rrptr_first",  32'(qget(glog, 1)), 32'd2);
        check("rrptr_second", 32'(qget(glog, 2)), 32'd0);

        // Round-robin fairness
        reset_dut();
        for (int i = 0; i < N; i++) push_word(i, 'h10 + i, 1);
        push_word(0, 'h20, 1);
        repeat (14) step();
        check("rr_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("rr_order", 32'(qget(glog, i)), 32'(i % N));

        // Burst limit
        reset_dut();
        push_burst(2, 20, 1);
        push_burst(3, 2, 1);
        repeat (32) step();
        check("limit_g0", 32'(qget(glog, 0)), 32'd2);
        check("limit_g1", 32'(qget(glog, 1)), 32'd3);
        check("limit_g2", 32'(qget(glog, 2)), 32'd2);
        check("limit_b0", 32'(qget(blog, 0)), 32'd16);
        check("limit_b1", 32'(qget(blog, 1)), 32'd2);
        check("limit_b2", 32'(qget(blog, 2)), 32'd4);

        // Backpressure and valid gaps
        reset_dut();
        push_burst(0, 6, 1);
        push_burst(1, 1, 1);
        wait_words(2, "bp_wait");
        full_drv = 1'b1;
        repeat (5) step();
        full_drv = 1'b0;
        gate[0] = 1'b0;
        repeat (3) step();
        check("bp_hold_grant", 32'(bus.Grant), 32'b0001);
        gate[0] = 1'b1;
        repeat (12) step();
        check("bp_g0",  32'(qget(glog, 0)), 32'd0);
        check("bp_g1",  32'(qget(glog, 1)), 32'd1);
        check("bp_len", 32'(qget(blog, 0)), 32'd6);

        // Reset mid-burst
        reset_dut();
        push_burst(1, 8, 1);
        wait_words(2, "rst_mid_wait");
        push_word(0, 'h01, 1); push_word(2, 'h02, 1); push_word(3, 'h03, 1);
        ainit_drv = 1'b1;
        step();
        step();
        ainit_drv = 1'b0;
        glog.delete();
        step();
        check("rst_mid_grant",   32'(bus.Grant),      32'd0);
        check("rst_mid_wr_en",   32'(bus.Fifo_wr_en), 32'd0);
        check("rst_mid_ack_err", 32'(bus.Ack_err),    32'd0);
        repeat (20) step();
        check("rst_mid_winner", 32'(qget(glog, 0)), 32'd0);

        // Dropped write acknowledge
        reset_dut();
        drop_at = 3;
        push_burst(0, 5, 1);
        repeat (10) step();
        check("ack_err_set", 32'(bus.Ack_err), 32'(ACK_EN));
        push_burst(1, 3, 1);
        repeat (6) step();
        check("ack_err_sticky", 32'(bus.Ack_err), 32'(ACK_EN));
        reset_dut();
        check("ack_err_clear", 32'(bus.Ack_err), 32'd0);

        // Randomized traffic against the model
        reset_dut();
        full_pct = 25; gate_pct = 85; rand_drop_pct = 4;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (head[i] == tail[i] && $urandom_range(0, 3) == 0)
                    push_burst(i, int'($urandom_range(1, 22)), $urandom_range(0, 7) != 0);
            ainit_drv = ($urandom_range(0, 299) == 0);
            step();
        end
        ainit_drv = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/emaclite_fifo_wr_arbiter.md
# emaclite_fifo_wr_arbiter

Round-robin, burst-locked arbiter that shares the write port of the emaclite async FIFO among `C_NUM_REQ` requesters in the `Wr_clk` domain.
- Grants one requester at a time and holds the grant until that requester's burst ends (last word, or the forced burst limit).
- Drives the FIFO `Din`/`Wr_en`, honours `Full`, and optionally checks every write against the FIFO `Wr_ack`.
- Sits between the MAC-side producers (e.g. TX descriptor path and loopback/pause injector) and the write side of the FIFO.

## Interface
Parameters:
- `C_NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `C_DATA_WIDTH`, 6: word width; matches the FIFO data width.
- `C_MAX_BURST`, 16: maximum words per grant; must be ≥ 1.

Ports:
- `Wr_clk`  in  1  single clock, the same as the FIFO write clock.
- `Ainit`  in  1  reset; synchronous to `Wr_clk`, active-high.
- `Req_valid`  in  C_NUM_REQ  requester i has a word on its data lane.
- `Req_last`  in  C_NUM_REQ  the word on lane i is the last word of its burst.
- `Req_data`  in  C_NUM_REQ*C_DATA_WIDTH  lane i occupies bits [i*W +: W].
- `Req_ready`  out  C_NUM_REQ  the word on lane i is accepted this cycle.
- `Grant`  out  C_NUM_REQ  one-hot registered grant.
- `Grant_id`  out  clog2(C_NUM_REQ)  index of the granted requester; 0 when idle.
- `Fifo_din`  out  C_DATA_WIDTH  connects to FIFO `Din`.
- `Fifo_wr_en`  out  1  connects to FIFO `Wr_en`.
- `Fifo_full`  in  1  FIFO `Full`; already includes the FIFO's reset-busy.
- `Fifo_wr_ack`  in  1  FIFO `Wr_ack`.
- `Ack_err`  out  1  sticky flag: a write was not acknowledged.

## Operation
State machine with two states, IDLE and BURST. Registers: state, `Grant`, round-robin pointer `rr_ptr`, burst counter `bcnt` (clog2(C_MAX_BURST+1) bits), write-pending bit, `Ack_err`.

IDLE:
- `Grant` = 0.
- If any `Req_valid` bit is set, select the first set bit at or after `rr_ptr`, searching upward with wrap-around from C_NUM_REQ-1 to 0.
- Register the one-hot grant, clear `bcnt`, and go to BURST.

BURST (granted requester g):
- `Fifo_wr_en` = `Req_valid[g]` & !`Fifo_full`.
- `Req_ready[g]` = `Fifo_wr_en`. All other `Req_ready` bits are 0.
- `Fifo_din` = lane g.
- On each transfer, `bcnt` increments.
- The burst ends on a transfer where `Req_last[g]`=1 or `bcnt`=C_MAX_BURST-1. At that point: `Grant` clears, `rr_ptr` = (g+1) mod C_NUM_REQ, go to IDLE.
- If `Req_valid[g]` drops mid-burst, the grant is held; no other requester can interleave.
- If `Fifo_full` is high, the requester stalls; `bcnt` and the grant are unchanged.

Outputs in IDLE: `Fifo_wr_en` = 0, `Fifo_din` = 0, all `Req_ready` = 0.

Reset (`Ainit`=1, including mid-burst):
- Next edge: state IDLE, `Grant` = 0, `Grant_id` = 0, `rr_ptr` = 0, `bcnt` = 0, pending bit = 0, `Ack_err` = 0.
- While `Ainit` is high, `Fifo_wr_en` = 0 and `Req_ready` = 0 combinationally.
- Any burst in flight is abandoned; the requester must restart it.

## Timing
- Arbitration latency: `Req_valid` rising in IDLE gives `Grant` at the next edge. The first transfer can occur in the cycle after that edge.
- `Fifo_wr_en`, `Req_ready` and `Fifo_din` are combinational from registered `Grant`, `Req_valid`, `Req_data` and `Fifo_full`. There is no registered data stage.
- Release: after the last transfer the arbiter spends one IDLE cycle before the next grant. Maximum throughput is C_MAX_BURST words per C_MAX_BURST+1 cycles.
- Simultaneous requests resolve strictly by `rr_ptr` order, so every active requester is served within C_NUM_REQ grants.
- A last word accepted on the same transfer where `bcnt` = C_MAX_BURST-1 counts as a single release.
- Ack check: the pending bit is `Fifo_wr_en` delayed by one cycle. If pending=1 and `Fifo_wr_ack`=0, `Ack_err` sets on the next edge. Only `Ainit` clears it.

## Configuration
- `EMACLITE_ARB_ACK_CHECK_EN` defined: the pending bit and `Ack_err` logic are compiled in as described above.
- Not defined: the pending bit and `Ack_err` logic are removed. `Ack_err` is tied to 0 and `Fifo_wr_ack` is ignored.

## Test plan
- Single requester: `Req_valid[1]`=1 with 3 words 0x11, 0x22, 0x33 (`Req_last` on 0x33), `Fifo_full`=0 → `Grant`=4'b0010 one cycle after valid; 3 consecutive `Fifo_wr_en` pulses with `Fifo_din` 0x11/0x22/0x33; IDLE afterwards; `rr_ptr`=2.
- Round-robin fairness: all 4 requesters valid, each with 1-word bursts → grant order 0,1,2,3,0; each grant separated by one IDLE cycle.
- Burst limit with C_MAX_BURST=16: requester 2 streams 20 words with no `Req_last` → grant released after exactly 16 transfers; requester 3 (also valid) is granted next; requester 2 resumes later for the remaining 4 words.
- Backpressure and gaps: `Fifo_full`=1 for 5 cycles mid-burst, then `Req_valid[g]`=0 for 3 cycles → no `Fifo_wr_en`, `Grant` held, `bcnt` unchanged, no other requester granted; the burst completes with the correct word count.
- Reset mid-burst: assert `Ainit` after the 2nd of 8 words → next edge `Grant`=0, `Fifo_wr_en`=0, `Ack_err`=0, `rr_ptr`=0; after release, requester 0 wins if all are valid.
- With `EMACLITE_ARB_ACK_CHECK_EN` defined, the FIFO model drops the ack for the 3rd write → `Ack_err`=1 two cycles after that write, and it stays 1 until `Ainit`. With the macro undefined, `Ack_err` stays 0 throughout.
